// File: rtl/motor_pkg.sv
// Shared types and constants for the quad motor BEMF sampler.
package motor_pkg;

    localparam int unsigned NUM_MOT = 4;

    // ADC channel wired to motor 0; motor i sits at this + i
    localparam logic [3:0] BEMF_CH_BASE_DEF = 4'd8;

    // Driver pin codes as {top, bottom}
    localparam logic [1:0] PIN_FWD   = 2'b10;
    localparam logic [1:0] PIN_REV   = 2'b01;
    localparam logic [1:0] PIN_BRAKE = 2'b11;
    localparam logic [1:0] PIN_IDLE  = 2'b00;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StAcc
    } bemf_state_e;

    // Any pin code other than the floating one means the bridge is driving the winding
    function automatic logic pins_driven(input logic top, input logic bot);
        return {top, bot} != PIN_IDLE;
    endfunction

endpackage

// File: rtl/quad_motor_bemf_if.sv
// ADC request/result handshake between the BEMF sampler and the shared ADC.
interface quad_motor_bemf_if #(
    parameter int unsigned ADC_W = 10
);

    logic             adc_req;
    logic [3:0]       adc_chan;
    logic             adc_gnt;
    logic             adc_valid;
    logic [ADC_W-1:0] adc_data;

    modport master (
        output adc_req,
        output adc_chan,
        input  adc_gnt,
        input  adc_valid,
        input  adc_data
    );

    modport slave (
        input  adc_req,
        input  adc_chan,
        output adc_gnt,
        output adc_valid,
        output adc_data
    );

endinterface

// File: rtl/bemf_settle_timer.sv
// Per-motor float timer: counts how long the bridge has been floating and
// remembers whether this float window has already produced an accepted sample.
module bemf_settle_timer #(
    parameter int unsigned SETTLE_CYC = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic driven,
    input  logic mark_sampled,
    output logic eligible
);

    localparam int unsigned     CNT_W   = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYC);

    logic [CNT_W-1:0] settle_cnt_q;
    logic             sampled_q;

    // Restart the window whenever the bridge drives; otherwise count up to the settle limit
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt_q <= '0;
            sampled_q    <= 1'b0;
        end else if (driven) begin
            settle_cnt_q <= '0;
            sampled_q    <= 1'b0;
        end else begin
            if (settle_cnt_q != CNT_MAX) begin
                settle_cnt_q <= settle_cnt_q + CNT_W'(1);
            end
            if (mark_sampled) begin
                sampled_q <= 1'b1;
            end
        end
    end

    assign eligible = (settle_cnt_q == CNT_MAX) && !sampled_q;

endmodule

// File: rtl/quad_motor_bemf.sv
// Back-EMF sampler for four H-bridge channels. Detects each motor's floating
// window, requests one ADC conversion per window after it settles, and
// accumulates the offset-corrected result into a signed position counter.
module quad_motor_bemf
    import motor_pkg::*;
#(
    parameter int unsigned SETTLE_CYC   = 200,
    parameter int unsigned ADC_W        = 10,
    parameter int unsigned POS_W        = 32,
    parameter logic [3:0]  BEMF_CH_BASE = BEMF_CH_BASE_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              MTOP,
    input  logic [3:0]              MBOT,
    input  logic                    sample_en,
    input  logic [ADC_W-1:0]        bemf_offset,
    input  logic [3:0]              pos_clear,
    quad_motor_bemf_if.master       adc,
    output logic signed [ADC_W:0]   bemf0,
    output logic signed [ADC_W:0]   bemf1,
    output logic signed [ADC_W:0]   bemf2,
    output logic signed [ADC_W:0]   bemf3,
    output logic signed [POS_W-1:0] pos0,
    output logic signed [POS_W-1:0] pos1,
    output logic signed [POS_W-1:0] pos2,
    output logic signed [POS_W-1:0] pos3,
    output logic [3:0]              bemf_update
);

    bemf_state_e            state_q;
    logic [1:0]             ptr_q;
    logic [1:0]             tgt_q;
    logic                   taint_q;
    logic [ADC_W-1:0]       data_q;
    logic                   adc_req_q;
    logic [3:0]             adc_chan_q;
    logic [3:0]             bemf_update_q;
    logic signed [ADC_W:0]  bemf_q [NUM_MOT];
    logic signed [POS_W-1:0] pos_q [NUM_MOT];

    logic [NUM_MOT-1:0]     driven;
    logic [NUM_MOT-1:0]     eligible;
    logic [NUM_MOT-1:0]     mark_sampled;
    logic                   in_flight;
    logic                   acc_keep;
    logic signed [ADC_W:0]  bemf_new;
    logic [POS_W-1:0]       pos_base;
    logic [POS_W-1:0]       pos_new;

    assign in_flight = (state_q == StReq) || (state_q == StWait);
    assign acc_keep  = (state_q == StAcc) && !taint_q;

    for (genvar i = 0; i < NUM_MOT; i++) begin : g_mot
        assign driven[i]       = pins_driven(MTOP[i], MBOT[i]);
        assign mark_sampled[i] = acc_keep && (tgt_q == 2'(i));

        bemf_settle_timer #(
            .SETTLE_CYC (SETTLE_CYC)
        ) u_timer (
            .clk          (clk),
            .reset        (reset),
            .driven       (driven[i]),
            .mark_sampled (mark_sampled[i]),
            .eligible     (eligible[i])
        );
    end

    // Offset correction and accumulation for the motor currently in ACC; a clear
    // in the same cycle zeroes the old count before the new sample is added
    always_comb begin
        bemf_new = $signed({1'b0, data_q}) - $signed({1'b0, bemf_offset});
        pos_base = pos_clear[tgt_q] ? '0 : pos_q[tgt_q];
        pos_new  = pos_base + {{(POS_W - ADC_W - 1){bemf_new[ADC_W]}}, bemf_new};
    end

    // Round-robin sampling FSM with registered ADC handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            tgt_q         <= '0;
            taint_q       <= 1'b0;
            data_q        <= '0;
            adc_req_q     <= 1'b0;
            adc_chan_q    <= '0;
            bemf_update_q <= '0;
            for (int i = 0; i < NUM_MOT; i++) begin
                bemf_q[i] <= '0;
                pos_q[i]  <= '0;
            end
        end else begin
            bemf_update_q <= '0;

            for (int i = 0; i < NUM_MOT; i++) begin
                if (pos_clear[i]) begin
                    pos_q[i] <= '0;
                end
            end

            // Target re-driven while its conversion is outstanding: the result no
            // longer describes a settled float window
            if (in_flight && driven[tgt_q]) begin
                taint_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (sample_en && eligible[ptr_q]) begin
                        tgt_q      <= ptr_q;
                        taint_q    <= driven[ptr_q];
                        adc_req_q  <= 1'b1;
                        adc_chan_q <= BEMF_CH_BASE + {2'b00, ptr_q};
                        state_q    <= StReq;
                    end else begin
                        ptr_q <= ptr_q + 2'd1;
                    end
                end
                StReq: begin
                    if (adc.adc_gnt) begin
                        adc_req_q <= 1'b0;
                        if (adc.adc_valid) begin
                            data_q  <= adc.adc_data;
                            state_q <= StAcc;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (adc.adc_valid) begin
                        data_q  <= adc.adc_data;
                        state_q <= StAcc;
                    end
                end
                StAcc: begin
                    if (!taint_q) begin
                        bemf_q[tgt_q]        <= bemf_new;
                        pos_q[tgt_q]         <= pos_new;
                        bemf_update_q[tgt_q] <= 1'b1;
                    end
                    ptr_q   <= tgt_q + 2'd1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign adc.adc_req  = adc_req_q;
    assign adc.adc_chan = adc_chan_q;
    assign bemf_update  = bemf_update_q;

    assign bemf0 = bemf_q[0];
    assign bemf1 = bemf_q[1];
    assign bemf2 = bemf_q[2];
    assign bemf3 = bemf_q[3];
    assign pos0  = pos_q[0];
    assign pos1  = pos_q[1];
    assign pos2  = pos_q[2];
    assign pos3  = pos_q[3];

endmodule

// File: tb/tb_quad_motor_bemf.sv
// Scoreboard bench for quad_motor_bemf. The position counter is built 16 bits
// wide so two's-complement wrap can be reached with a few dozen samples
// (0x7FC0 + 100 -> 0x8024 is the narrow form of 0x7FFFFFC0 + 100 -> 0x80000024).
module tb_quad_motor_bemf;

    localparam int unsigned SETTLE_CYC = 200;
    localparam int unsigned ADC_W      = 10;
    localparam int unsigned POS_W      = 16;

    typedef struct {
        int motor;
        int bemf;
        int pos;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [3:0]              MTOP;
    logic [3:0]              MBOT;
    logic                    sample_en;
    logic [ADC_W-1:0]        bemf_offset;
    logic [3:0]              pos_clear;
    logic signed [ADC_W:0]   bemf0, bemf1, bemf2, bemf3;
    logic signed [POS_W-1:0] pos0, pos1, pos2, pos3;
    logic [3:0]              bemf_update;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    quad_motor_bemf_if #(.ADC_W(ADC_W)) adc_if ();

    quad_motor_bemf #(
        .SETTLE_CYC   (SETTLE_CYC),
        .ADC_W        (ADC_W),
        .POS_W        (POS_W),
        .BEMF_CH_BASE (4'd8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .MTOP        (MTOP),
        .MBOT        (MBOT),
        .sample_en   (sample_en),
        .bemf_offset (bemf_offset),
        .pos_clear   (pos_clear),
        .adc         (adc_if),
        .bemf0       (bemf0),
        .bemf1       (bemf1),
        .bemf2       (bemf2),
        .bemf3       (bemf3),
        .pos0        (pos0),
        .pos1        (pos1),
        .pos2        (pos2),
        .pos3        (pos3),
        .bemf_update (bemf_update)
    );

    always #5 clk = ~clk;

    function automatic int bemf_of(input int m);
        case (m)
            0: return int'(bemf0);
            1: return int'(bemf1);
            2: return int'(bemf2);
            default: return int'(bemf3);
        endcase
    endfunction

    function automatic int pos_of(input int m);
        case (m)
            0: return int'(pos0);
            1: return int'(pos1);
            2: return int'(pos2);
            default: return int'(pos3);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, int'(adc_if.adc_req), 0);
        check({tag, "_upd"}, int'(bemf_update), 0);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("%s_bemf%0d", tag, m), bemf_of(m), 0);
            check($sformatf("%s_pos%0d", tag, m), pos_of(m), 0);
        end
    endtask

    task automatic wait_req(input int budget, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (adc_if.adc_req) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL req_timeout: adc_req got 0 expected 1 within %0d cycles", budget);
        end
    endtask

    task automatic expect_no_req(input string name, input int n);
        bit seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (adc_if.adc_req) seen = 1'b1;
        end
        check(name, int'(seen), 0);
    endtask

    // Called at the negedge where adc_req is seen high; grants immediately.
    // delay 0 returns data with the grant, otherwise delay cycles after it.
    task automatic adc_txn(input int data, input int delay, input int redrive_m,
                           input int clear_m, input bit drop_en);
        adc_if.adc_gnt   = 1'b1;
        adc_if.adc_valid = (delay == 0);
        adc_if.adc_data  = ADC_W'(data);
        @(negedge clk);
        adc_if.adc_gnt = 1'b0;
        check("req_drop", int'(adc_if.adc_req), 0);
        if (delay > 0) begin
            adc_if.adc_valid = 1'b0;
            if (redrive_m >= 0) MTOP[redrive_m] = 1'b1;
            if (drop_en) sample_en = 1'b0;
            tick(delay - 1);
            adc_if.adc_valid = 1'b1;
            @(negedge clk);
        end
        adc_if.adc_valid = 1'b0;
        if (clear_m >= 0) pos_clear[clear_m] = 1'b1;
        @(negedge clk);
        pos_clear = '0;
    endtask

    // Float one motor, expect its request and the given hand-computed result
    task automatic sample_motor(input int m, input int data, input int delay,
                                input int exp_bemf, input int exp_pos,
                                input int clear_m, input bit hold);
        int cyc;
        bit ok;
        MTOP = 4'hF & ~(4'b0001 << m);
        MBOT = 4'h0;
        wait_req(400, cyc, ok);
        if (ok) begin
            checks++;
            if (cyc < int'(SETTLE_CYC)) begin
                errors++;
                $display("FAIL req_settle: got %0d cycles expected >= %0d", cyc, SETTLE_CYC);
            end
            check("chan", int'(adc_if.adc_chan), 8 + m);
            sb_q.push_back('{motor: m, bemf: exp_bemf, pos: exp_pos});
            adc_txn(data, delay, -1, clear_m, 1'b0);
            if (hold) expect_no_req("no_resample", 300);
        end
        MTOP = 4'hF;
        tick(1);
    endtask

    // Monitor: every update pulse must match the next scoreboard entry
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                for (int m = 0; m < 4; m++) begin
                    if (bemf_update[m]) begin
                        if (sb_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_update: motor %0d pulsed, expected no pulse", m);
                        end else begin
                            exp_t e;
                            e = sb_q.pop_front();
                            check("upd_motor", m, e.motor);
                            check("upd_bemf", bemf_of(m), e.bemf);
                            check("upd_pos", pos_of(m), e.pos);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        bit ok;
        int m;
        int first;
        int exp6[4] = '{-32632, 210, 20, 130};

        reset            = 1'b1;
        MTOP             = 4'hF;
        MBOT             = 4'h0;
        sample_en        = 1'b1;
        bemf_offset      = 10'd512;
        pos_clear        = '0;
        adc_if.adc_gnt   = 1'b0;
        adc_if.adc_valid = 1'b0;
        adc_if.adc_data  = '0;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // Motor0 floats alone: 612 - 512 = +100, no second request in the window
        sample_motor(0, 612, 1, 100, 100, -1, 1'b1);

        // Reset while waiting on the ADC, then a stray result
        MTOP = 4'b1110;
        wait_req(400, cyc, ok);
        if (ok) begin
            adc_if.adc_gnt = 1'b1;
            @(negedge clk);
            adc_if.adc_gnt = 1'b0;
            reset          = 1'b1;
            MTOP           = 4'hF;
            @(negedge clk);
            check_all_zero("midreset");
            reset            = 1'b0;
            adc_if.adc_valid = 1'b1;
            adc_if.adc_data  = 10'd700;
            @(negedge clk);
            adc_if.adc_valid = 1'b0;
            expect_no_req("stray_no_req", 6);
            check("stray_pos0", int'(pos0), 0);
        end

        // Motor1 re-driven between grant and result: sample discarded, retried next window
        MTOP = 4'b1101;
        wait_req(400, cyc, ok);
        if (ok) begin
            check("taint_chan", int'(adc_if.adc_chan), 9);
            adc_txn(700, 2, 1, -1, 1'b0);
            tick(4);
            check("taint_bemf1", int'(bemf1), 0);
            check("taint_pos1", int'(pos1), 0);
        end
        MTOP = 4'hF;
        tick(1);
        sample_motor(1, 612, 1, 100, 100, -1, 1'b0);

        // Build pos2 to 5000, then clear it in the ACC cycle of a -100 sample
        bemf_offset = 10'd0;
        for (int k = 0; k < 5; k++) begin
            sample_motor(2, 1000, k % 3, 1000, 1000 * (k + 1), -1, 1'b0);
        end
        check("pos2_5000", int'(pos2), 5000);
        bemf_offset = 10'd512;
        sample_motor(2, 412, 1, -100, -100, 2, 1'b0);

        // Wrap: 32 * 1022 = 32704 = 0x7FC0, + 100 = 0x8024 = -32732
        bemf_offset = 10'd0;
        for (int k = 0; k < 32; k++) begin
            sample_motor(0, 1022, 0, 1022, 1022 * (k + 1), -1, 1'b0);
        end
        check("pos0_7fc0", int'(pos0), 32704);
        bemf_offset = 10'd512;
        sample_motor(0, 612, 2, 100, -32732, -1, 1'b0);

        // All four float: round-robin service, sample_en dropped during the last WAIT
        first = 0;
        MTOP  = 4'h0;
        for (int k = 0; k < 4; k++) begin
            wait_req(400, cyc, ok);
            if (ok) begin
                m = int'(adc_if.adc_chan) - 8;
                if (k == 0) first = m;
                else check("rr_order", m, (first + k) % 4);
                if (m >= 0 && m < 4) begin
                    sb_q.push_back('{motor: m, bemf: 100 + 10 * m, pos: exp6[m]});
                    adc_txn(612 + 10 * m, (k == 3) ? 2 : k % 2, -1, -1, k == 3);
                end else begin
                    check("rr_chan_range", m, 0);
                end
            end
        end
        expect_no_req("all_sampled", 300);
        MTOP = 4'hF;
        tick(1);
        MTOP = 4'h0;
        expect_no_req("en_low_block", 300);
        sample_en = 1'b1;
        wait_req(10, cyc, ok);
        if (ok) begin
            m = int'(adc_if.adc_chan) - 8;
            if (m >= 0 && m < 4) begin
                sb_q.push_back('{motor: m, bemf: 100, pos: exp6[m] + 100});
                adc_txn(612, 1, -1, -1, 1'b0);
            end else begin
                check("en_chan_range", m, 0);
            end
        end
        MTOP = 4'hF;
        tick(5);
        check("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
